// File: rtl/dm_cache_ctrl_pkg.sv
// Shared types and geometry for the direct-mapped cache controller.
// 1024 lines of 16 bytes; address = tag[31:14] | index[13:4] | word[3:2] | byte[1:0].
package icache_def;

  localparam int TAGMSB = 31;
  localparam int TAGLSB = 14;

  typedef struct packed {
    logic                valid;
    logic                dirty;
    logic [TAGMSB:TAGLSB] tag;
  } cache_tag_type;

  typedef struct packed {
    logic [9:0] index;
    logic       we;
  } cache_req_type;

  typedef logic [127:0] cache_data_type;

  typedef struct packed {
    logic        valid;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] data;
  } cpu_req_type;

  typedef struct packed {
    logic        ready;
    logic [31:0] data;
  } cpu_result_type;

  typedef struct packed {
    logic           valid;
    logic           rw;
    logic [31:0]    addr;
    cache_data_type data;
  } mem_req_type;

  typedef struct packed {
    logic           ready;
    cache_data_type data;
  } mem_data_type;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    COMPARE    = 2'd1,
    WRITE_BACK = 2'd2,
    ALLOCATE   = 2'd3
  } cache_state_type;

  function automatic logic [31:0] word_sel(input cache_data_type blk, input logic [1:0] w);
    return blk[32*w +: 32];
  endfunction

  function automatic cache_data_type word_put(input cache_data_type blk, input logic [1:0] w,
                                              input logic [31:0] d);
    cache_data_type r;
    r = blk;
    r[32*w +: 32] = d;
    return r;
  endfunction

endpackage

// File: rtl/dm_cache_ctrl_if.sv
// Bundle of every bus the cache controller touches; master = controller side.
interface dm_cache_ctrl_if;
  import icache_def::*;

  // cpu_req.valid is sampled only in IDLE; cpu_res.ready pulses one cycle per accepted request.
  // mem_req.valid holds with stable fields until a cycle with mem_res.ready=1 completes it.
  cpu_req_type     cpu_req;
  cpu_result_type  cpu_res;
  mem_req_type     mem_req;
  mem_data_type    mem_res;
  cache_req_type   tag_req;
  cache_req_type   data_req;
  cache_tag_type   tag_write;
  cache_tag_type   tag_read;
  cache_data_type  data_write;
  cache_data_type  data_read;
  cache_state_type fsm_state;

  modport master (
    input  cpu_req, mem_res, tag_read, data_read,
    output cpu_res, mem_req, tag_req, data_req, tag_write, data_write, fsm_state
  );

  modport slave (
    output cpu_req, mem_res, tag_read, data_read,
    input  cpu_res, mem_req, tag_req, data_req, tag_write, data_write, fsm_state
  );

endinterface

// File: rtl/dm_cache_ctrl.sv
// Write-back, write-allocate direct-mapped cache controller. Tag and data arrays live
// outside; this block drives their index/we and decides hit, write-back and refill.
module dm_cache_ctrl
  import icache_def::*;
(
  input logic             clk,
  input logic             rst_n,
  dm_cache_ctrl_if.master bus
);

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_COMPARE    = 2'd1;
  localparam logic [1:0] ST_WRITE_BACK = 2'd2;
  localparam logic [1:0] ST_ALLOCATE   = 2'd3;

  logic [1:0]           state_q;
  logic [1:0]           state_d;
  cpu_req_type          req_q;
  logic [TAGMSB:TAGLSB] req_tag;
  logic [9:0]           req_index;
  logic [1:0]           req_word;
  logic                 hit;

  cpu_result_type cpu_res;
  mem_req_type    mem_req;
  cache_req_type  tag_req;
  cache_req_type  data_req;
  cache_tag_type  tag_write;
  cache_data_type data_write;

  assign req_tag   = req_q.addr[TAGMSB:TAGLSB];
  assign req_index = req_q.addr[13:4];
  assign req_word  = req_q.addr[3:2];
  assign hit       = bus.tag_read.valid && (bus.tag_read.tag == req_tag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && bus.cpu_req.valid) begin
        req_q <= bus.cpu_req;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    cpu_res        = '0;
    mem_req        = '0;
    tag_req.index  = req_index;
    tag_req.we     = 1'b0;
    data_req.index = req_index;
    data_req.we    = 1'b0;
    tag_write      = '0;
    data_write     = bus.data_read;

    case (state_q)
      ST_IDLE: begin
        if (bus.cpu_req.valid) state_d = ST_COMPARE;
      end

      ST_COMPARE: begin
        if (hit) begin
          cpu_res.ready = 1'b1;
          cpu_res.data  = word_sel(bus.data_read, req_word);
          if (req_q.rw) begin
            data_req.we = 1'b1;
            data_write  = word_put(bus.data_read, req_word, req_q.data);
            tag_req.we  = 1'b1;
            tag_write   = '{valid: 1'b1, dirty: 1'b1, tag: req_tag};
          end
          state_d = ST_IDLE;
        end else if (bus.tag_read.valid && bus.tag_read.dirty) begin
          state_d = ST_WRITE_BACK;
        end else begin
          state_d = ST_ALLOCATE;
        end
      end

      // Victim address and block come straight from the arrays at the held index, so
      // they stay stable for as long as memory stalls.
      ST_WRITE_BACK: begin
        mem_req.valid = 1'b1;
        mem_req.rw    = 1'b1;
        mem_req.addr  = {bus.tag_read.tag, req_index, 4'b0000};
        mem_req.data  = bus.data_read;
        if (bus.mem_res.ready) state_d = ST_ALLOCATE;
      end

      ST_ALLOCATE: begin
        mem_req.valid = 1'b1;
        mem_req.rw    = 1'b0;
        mem_req.addr  = {req_tag, req_index, 4'b0000};
        if (bus.mem_res.ready) begin
          data_req.we = 1'b1;
          data_write  = bus.mem_res.data;
          tag_req.we  = 1'b1;
          tag_write   = '{valid: 1'b1, dirty: 1'b0, tag: req_tag};
          state_d     = ST_COMPARE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.cpu_res    = cpu_res;
  assign bus.mem_req    = mem_req;
  assign bus.tag_req    = tag_req;
  assign bus.data_req   = data_req;
  assign bus.tag_write  = tag_write;
  assign bus.data_write = data_write;
  assign bus.fsm_state  = cache_state_type'(state_q);

endmodule
